aes_ctr_pad_stream: RTL

- Parametrised AES-CTR keystream generator with NUM_AES parallel 128-bit `aes` cores; replaces the fixed 4/8/16-core define-selected pad generator.
- Accepts one request (nonce, start counter, length in 512-bit pad words).
- Streams exactly that many pad words, re-issuing core batches with correctly advanced per-core counters.
- Sits between the memory-encryption front end and the XOR datapath.

---
 rtl/aes_pad_pkg.sv | 15 +
 rtl/aes_ctr_pad_stream_aes.sv | 64 ++++++
 rtl/shield_muxp.sv | 20 ++
 rtl/aes_ctr_pad_stream.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/aes_pad_pkg.sv
// Shared types and constants for the AES-CTR pad stream.
// Holds the FSM state enum and the block/pad geometry.
package aes_pad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        STREAM
    } state_e;

    localparam int AES_BLOCK_W   = 128;
    localparam int PAD_W         = 512;
    localparam int LANES_PER_PAD = 4;

endpackage

// File: rtl/aes_ctr_pad_stream_aes.sv
// Behavioural stand-in for the 128-bit AES core: same handshake and
// fixed latency as the real core, but the CTR block {nonce, counter}
// comes out unencrypted.
// Ports: req_val_i/req_rdy_o accept one block (nonce_i, counter_i);
// pad_o/pad_val_o/pad_rdy_i return it LATENCY cycles later.
module aes #(
    parameter int DATA_WIDTH = 128,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_val_i,
    output logic                  req_rdy_o,
    input  logic [95:0]           nonce_i,
    input  logic [31:0]           counter_i,
    output logic [DATA_WIDTH-1:0] pad_o,
    output logic                  pad_val_o,
    input  logic                  pad_rdy_i
);

    localparam int CW = $clog2(LATENCY + 1);

    logic                  busy_q, busy_d;
    logic                  val_q, val_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] blk_q, blk_d;

    always_comb begin
        busy_d = busy_q;
        val_d  = val_q;
        cnt_d  = cnt_q;
        blk_d  = blk_q;
        if (!busy_q && req_val_i) begin
            busy_d = 1'b1;
            cnt_d  = CW'(LATENCY - 1);
            blk_d  = DATA_WIDTH'({nonce_i, counter_i});
        end else if (busy_q && !val_q) begin
            if (cnt_q == '0) val_d = 1'b1;
            else             cnt_d = cnt_q - CW'(1);
        end else if (val_q && pad_rdy_i) begin
            val_d  = 1'b0;
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            val_q  <= 1'b0;
            cnt_q  <= '0;
            blk_q  <= '0;
        end else begin
            busy_q <= busy_d;
            val_q  <= val_d;
            cnt_q  <= cnt_d;
            blk_q  <= blk_d;
        end
    end

    assign req_rdy_o = !busy_q;
    assign pad_o     = blk_q;
    assign pad_val_o = val_q;

endmodule

// File: rtl/shield_muxp.sv
// One-hot-free N:1 word multiplexer on a packed bus.
// Ports: data_i (N words of WIDTH), sel_i (word index), data_o.
module shield_muxp #(
    parameter int WIDTH = 512,
    parameter int N     = 2,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic [WIDTH-1:0]   data_o
);

    always_comb begin
        data_o = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_i == SEL_W'(i)) data_o = data_i[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/aes_ctr_pad_stream.sv
// AES-CTR keystream generator: NUM_AES parallel cores, streams req_len
// 512-bit pad words for one (nonce, counter) request.
// Ports: req_* request handshake; pad/pad_val/pad_rdy/pad_last output
// stream; busy high whenever not idle.
module aes_ctr_pad_stream
    import aes_pad_pkg::*;
#(
    parameter int NUM_AES   = 4,
    parameter int LEN_WIDTH = 16,
    parameter int PAD_WIDTH = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [95:0]          req_nonce,
    input  logic [31:0]          req_counter,
    input  logic [LEN_WIDTH-1:0] req_len,
    input  logic                 req_val,
    output logic                 req_rdy,
    output logic [PAD_WIDTH-1:0] pad,
    output logic                 pad_val,
    input  logic                 pad_rdy,
    output logic                 pad_last,
    output logic                 busy
);

    localparam int BURSTS = NUM_AES / LANES_PER_PAD;
    localparam int BW     = (BURSTS > 1) ? $clog2(BURSTS) : 1;

    if (!(NUM_AES == 4 || NUM_AES == 8 ||
          NUM_AES == 16 || NUM_AES == 32)) begin : g_bad_num
        $error("NUM_AES must be 4, 8, 16 or 32");
    end
    if (PAD_WIDTH != PAD_W) begin : g_bad_pad
        $error("PAD_WIDTH must be 512");
    end

    state_e               state_q, state_d;
    logic [95:0]          nonce_q, nonce_d;
    logic [31:0]          ctr_base_q, ctr_base_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic [BW-1:0]        burst_idx_q, burst_idx_d;

    logic                           core_req_val;
    logic                           core_pad_rdy;
    logic [NUM_AES-1:0]             core_req_rdy;
    logic [NUM_AES-1:0]             core_pad_val;
    logic [NUM_AES*AES_BLOCK_W-1:0] core_pad;

    logic all_rdy, all_val, last_word, batch_end;

    assign all_rdy   = &core_req_rdy;
    assign all_val   = &core_pad_val;
    assign last_word = remaining_q == LEN_WIDTH'(1);
    assign batch_end = last_word || burst_idx_q == BW'(BURSTS - 1);

    for (genvar i = 0; i < NUM_AES; i++) begin : g_core
        aes #(
            .DATA_WIDTH(AES_BLOCK_W)
        ) u_aes (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_val_i(core_req_val),
            .req_rdy_o(core_req_rdy[i]),
            .nonce_i  (nonce_q),
            .counter_i(ctr_base_q + 32'(i)),
            .pad_o    (core_pad[i*AES_BLOCK_W +: AES_BLOCK_W]),
            .pad_val_o(core_pad_val[i]),
            .pad_rdy_i(core_pad_rdy)
        );
    end

    if (BURSTS == 1) begin : g_nomux
        assign pad = core_pad[PAD_WIDTH-1:0];
    end else begin : g_mux
        shield_muxp #(
            .WIDTH(PAD_WIDTH),
            .N    (BURSTS),
            .SEL_W(BW)
        ) u_mux (
            .data_i(core_pad),
            .sel_i (burst_idx_q),
            .data_o(pad)
        );
    end

    always_comb begin
        state_d      = state_q;
        nonce_d      = nonce_q;
        ctr_base_d   = ctr_base_q;
        remaining_d  = remaining_q;
        burst_idx_d  = burst_idx_q;
        req_rdy      = 1'b0;
        core_req_val = 1'b0;
        core_pad_rdy = 1'b0;
        pad_val      = 1'b0;
        pad_last     = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_rdy = all_rdy;
                if (req_val && all_rdy) begin
                    nonce_d     = req_nonce;
                    ctr_base_d  = req_counter;
                    remaining_d = req_len;
                    burst_idx_d = '0;
                    // A zero-length request is consumed without output.
                    if (req_len != '0) state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (all_rdy) begin
                    core_req_val = 1'b1;
                    state_d      = STREAM;
                end
            end
            STREAM: begin
                pad_val  = all_val;
                pad_last = all_val && last_word;
                if (all_val && pad_rdy) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    burst_idx_d = burst_idx_q + BW'(1);
                    // Pop the whole batch; leftover lanes are dropped.
                    if (batch_end) begin
                        core_pad_rdy = 1'b1;
                        burst_idx_d  = '0;
                        ctr_base_d   = ctr_base_q + 32'(NUM_AES);
                        state_d      = last_word ? IDLE : ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            nonce_q     <= '0;
            ctr_base_q  <= '0;
            remaining_q <= '0;
            burst_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            nonce_q     <= nonce_d;
            ctr_base_q  <= ctr_base_d;
            remaining_q <= remaining_d;
            burst_idx_q <= burst_idx_d;
        end
    end

    assign busy = state_q != IDLE;

endmodule
